// File: rtl/capture_stream_ctrl_pkg.sv
// capture_stream_ctrl_pkg
//   Shared definitions for the capture/stream controller: default geometry,
//   FSM state encoding and the effective-count helper.
package capture_stream_ctrl_pkg;

  localparam int unsigned SAMPLE_W_DEF = 12;   // ADC sample width
  localparam int unsigned DEPTH_DEF    = 100;  // buffer capacity in samples
  localparam int unsigned CNT_W_DEF    = 7;    // counter width, 2^CNT_W > DEPTH

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // A requested count of 0, or one larger than the buffer, means "fill the buffer".
  function automatic int unsigned eff_count(input int unsigned cfg, input int unsigned depth);
    return ((cfg == 0) || (cfg > depth)) ? depth : cfg;
  endfunction

endpackage

// File: rtl/capture_stream_ctrl_if.sv
// capture_stream_ctrl_if
//   Handshake bundle between the controller, the ADC reader and the Arduino writer.
//   adc_req/adc_valid/adc_data : conversion request, one-cycle valid pulse, sample
//   tx_req/tx_data/tx_ack      : word ready, word, one-cycle completion pulse
//   master : controller side      slave : ADC reader / writer side
interface capture_stream_ctrl_if
  import capture_stream_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
);

  logic                adc_req;
  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                tx_req;
  logic [SAMPLE_W-1:0] tx_data;
  logic                tx_ack;

  modport master (
    output adc_req,
    input  adc_valid,
    input  adc_data,
    output tx_req,
    output tx_data,
    input  tx_ack
  );

  modport slave (
    input  adc_req,
    output adc_valid,
    output adc_data,
    input  tx_req,
    input  tx_data,
    output tx_ack
  );

endinterface

// File: rtl/capture_stream_ctrl_sample_mem.sv
// capture_stream_ctrl_sample_mem
//   DEPTH x SAMPLE_W sample buffer, one synchronous write port and one
//   registered read port. Contents are never reset; only the read register is.
//   clk, rst          : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata  : write strobe, address, data
//   re, raddr, rdata  : read enable, address, registered read data (holds when re=0)
module capture_stream_ctrl_sample_mem
  import capture_stream_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned AW       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem_q [DEPTH];
  logic [SAMPLE_W-1:0] rdata_q;

  // Storage array: write only, no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register: only advances while enabled so the word is stable otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/capture_stream_ctrl.sv
// capture_stream_ctrl
//   Captures a configurable number of ADC samples (optionally after a threshold
//   trigger) into a buffer, then drains them oldest-first to the Arduino writer.
//   One-shot or continuous (re-arming) operation.
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a run (IDLE only)
//   cfg_*           : count, trigger enable, threshold, continuous; latched at start
//   bus             : ADC req/valid and writer req/ack handshakes (master side)
//   busy, done      : not-IDLE flag, one-cycle end-of-drain pulse
//   captured        : samples stored this run
//   transmitted     : samples acknowledged this run
module capture_stream_ctrl
  import capture_stream_ctrl_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      cfg_count,
  input  logic                  cfg_trig_en,
  input  logic [SAMPLE_W-1:0]   cfg_threshold,
  input  logic                  cfg_continuous,
  capture_stream_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      captured,
  output logic [CNT_W-1:0]      transmitted
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    eff_q, eff_d;
  logic                trig_en_q, trig_en_d;
  logic [SAMPLE_W-1:0] thr_q, thr_d;
  logic                cont_q, cont_d;
  logic [CNT_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    captured_q, captured_d;
  logic [CNT_W-1:0]    transmitted_q, transmitted_d;
  logic                adc_req_q, adc_req_d;
  logic                tx_req_q, tx_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                mem_we;
  logic                mem_re;
  logic [SAMPLE_W-1:0] mem_rdata;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      eff_q         <= '0;
      trig_en_q     <= 1'b0;
      thr_q         <= '0;
      cont_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      captured_q    <= '0;
      transmitted_q <= '0;
      adc_req_q     <= 1'b0;
      tx_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      eff_q         <= eff_d;
      trig_en_q     <= trig_en_d;
      thr_q         <= thr_d;
      cont_q        <= cont_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      captured_q    <= captured_d;
      transmitted_q <= transmitted_d;
      adc_req_q     <= adc_req_d;
      tx_req_q      <= tx_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d       = state_q;
    eff_d         = eff_q;
    trig_en_d     = trig_en_q;
    thr_d         = thr_q;
    cont_d        = cont_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    captured_d    = captured_q;
    transmitted_d = transmitted_q;
    mem_we        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_ARM;
          eff_d         = CNT_W'(eff_count(32'(cfg_count), DEPTH));
          trig_en_d     = cfg_trig_en;
          thr_d         = cfg_threshold;
          cont_d        = cfg_continuous;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          captured_d    = '0;
          transmitted_d = '0;
        end
      end

      ST_ARM: begin
        if (!trig_en_q) begin
          state_d = ST_CAPTURE;
        end else if (bus.adc_valid && adc_req_q && (bus.adc_data >= thr_q)) begin
          // Trigger sample is itself the first stored sample.
          mem_we     = 1'b1;
          wr_ptr_d   = CNT_W'(1);
          captured_d = CNT_W'(1);
          state_d    = (eff_q == CNT_W'(1)) ? ST_DRAIN : ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (bus.adc_valid && adc_req_q) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + CNT_W'(1);
          captured_d = captured_q + CNT_W'(1);
          if (captured_d == eff_q) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (tx_req_q && bus.tx_ack) begin
          rd_ptr_d      = rd_ptr_q + CNT_W'(1);
          transmitted_d = transmitted_q + CNT_W'(1);
          if (transmitted_d == captured_q) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (cont_q) begin
          state_d       = ST_ARM;
          wr_ptr_d      = '0;
          rd_ptr_d      = '0;
          captured_d    = '0;
          transmitted_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    adc_req_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    // Word request: rises one cycle into DRAIN, drops for one cycle after each ack
    // while the read register fetches the next word.
    tx_req_d  = (state_q == ST_DRAIN) && (state_d == ST_DRAIN) && !(tx_req_q && bus.tx_ack);
  end

  // Read port only runs in DRAIN, so tx_data holds its value elsewhere.
  assign mem_re = (state_q == ST_DRAIN);

  capture_stream_ctrl_sample_mem #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .AW       (CNT_W)
  ) u_sample_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.adc_data),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  assign bus.adc_req  = adc_req_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.tx_data  = mem_rdata;
  assign busy         = busy_q;
  assign done         = done_q;
  assign captured     = captured_q;
  assign transmitted  = transmitted_q;

endmodule

// File: tb/tb_capture_stream_ctrl.sv
// tb_capture_stream_ctrl
//   Directed bench for capture_stream_ctrl: table of one-shot runs plus
//   sequences for continuous mode, count clamp, handshake abuse and reset mid-drain.
module tb_capture_stream_ctrl;
  import capture_stream_ctrl_pkg::*;

  localparam int unsigned SW    = 12;
  localparam int unsigned DEPTH = DEPTH_DEF;
  localparam int unsigned CW    = 7;
  localparam int          NV    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] cfg_count;
  logic          cfg_trig_en;
  logic [SW-1:0] cfg_threshold;
  logic          cfg_continuous;
  logic          busy;
  logic          done;
  logic [CW-1:0] captured;
  logic [CW-1:0] transmitted;

  capture_stream_ctrl_if #(.SAMPLE_W(SW)) bus ();

  capture_stream_ctrl #(
    .SAMPLE_W (SW),
    .DEPTH    (DEPTH),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_count      (cfg_count),
    .cfg_trig_en    (cfg_trig_en),
    .cfg_threshold  (cfg_threshold),
    .cfg_continuous (cfg_continuous),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .captured       (captured),
    .transmitted    (transmitted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [CW-1:0] count;
    logic          trig;
    logic [SW-1:0] thr;
    int            n_feed;
    logic [SW-1:0] feed [8];
    int            n_exp;
    logic [SW-1:0] exp_w [8];
  } vec_t;

  vec_t          vecs [NV];
  logic [SW-1:0] feed_q [$];
  logic [SW-1:0] exp_q  [$];
  logic [SW-1:0] got_q  [$];
  int            checks = 0;
  int            errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // One run: ADC model feeds feed_q (3-cycle spacing) while adc_req is high,
  // writer model acks each word after 3 sampled cycles of tx_req.
  task automatic run(input string nm, input logic [CW-1:0] cnt, input logic trg,
                     input logic [SW-1:0] thr, input logic cont, input int done_tgt,
                     input int stop_acks, input bit abuse, input int drop_at);
    int            fidx;
    int            gap;
    int            hold;
    int            n_done;
    int            stab_err;
    int            busy_drop;
    int            cnt_err;
    bit            prev_done;
    bit            chk_drop;
    bit            finished;
    logic [SW-1:0] held;
    fidx = 0; gap = 2; hold = 0; n_done = 0; stab_err = 0; busy_drop = 0; cnt_err = 0;
    prev_done = 0; chk_drop = 0; finished = 0; held = '0;
    got_q.delete();

    cfg_count = cnt; cfg_trig_en = trg; cfg_threshold = thr; cfg_continuous = cont;
    start = 1'b1;
    step();
    start = 1'b0;
    // Scramble the config pins: only the copy latched at start may matter.
    cfg_count = ~cnt; cfg_trig_en = ~trg; cfg_threshold = ~thr; cfg_continuous = ~cont;
    chk({nm, " busy_at_arm"}, 32'(busy), 32'd1);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (chk_drop) begin
        chk({nm, " adc_req_drop"}, 32'(bus.adc_req), 32'd0);
        chk_drop = 0;
      end
      if (stop_acks > 0 && got_q.size() >= stop_acks) begin finished = 1; break; end
      if (n_done >= done_tgt && !cont && !busy) begin finished = 1; break; end
      if (!busy) busy_drop++;
      if (prev_done && cont && (captured != '0 || transmitted != '0)) cnt_err++;
      prev_done = done;
      if (done) begin
        n_done++;
        gap = 3;
        if (cont && n_done >= done_tgt) begin finished = 1; break; end
      end
      if (bus.tx_req) begin
        if (hold == 0) held = bus.tx_data;
        else if (bus.tx_data !== held) stab_err++;
        hold++;
      end

      bus.adc_valid = 1'b0; bus.tx_ack = 1'b0; start = 1'b0; bus.adc_data = '0;
      if (bus.adc_req && gap == 0 && fidx < feed_q.size()) begin
        bus.adc_valid = 1'b1;
        bus.adc_data  = feed_q[fidx];
        fidx++;
        gap = 2;
        if (drop_at > 0 && fidx == drop_at) chk_drop = 1;
      end else if (gap > 0) begin
        gap--;
      end
      if (bus.tx_req && hold >= 3) begin
        bus.tx_ack = 1'b1;
        got_q.push_back(bus.tx_data);
        hold = 0;
      end
      if (abuse && busy && !done && !bus.tx_req && captured == cnt) begin
        bus.tx_ack = 1'b1; start = 1'b1; bus.adc_valid = 1'b1; bus.adc_data = 12'hBAD;
      end
      step();
    end
    bus.adc_valid = 1'b0; bus.tx_ack = 1'b0; start = 1'b0;

    chk({nm, " finished_in_budget"}, 32'(finished), 32'd1);
    chk({nm, " done_pulses"}, 32'(n_done), (stop_acks > 0) ? 32'd0 : 32'(done_tgt));
    chk({nm, " tx_data_stable"}, 32'(stab_err), 32'd0);
    chk({nm, " busy_held"}, 32'(busy_drop), 32'd0);
    if (cont) chk({nm, " counters_clear_at_arm"}, 32'(cnt_err), 32'd0);
    if (stop_acks == 0) chk({nm, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s word%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " busy"},        32'(busy),          32'd0);
    chk({nm, " done"},        32'(done),          32'd0);
    chk({nm, " adc_req"},     32'(bus.adc_req),   32'd0);
    chk({nm, " tx_req"},      32'(bus.tx_req),    32'd0);
    chk({nm, " tx_data"},     32'(bus.tx_data),   32'd0);
    chk({nm, " captured"},    32'(captured),      32'd0);
    chk({nm, " transmitted"}, 32'(transmitted),   32'd0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0;
    cfg_count = '0; cfg_trig_en = 1'b0; cfg_threshold = '0; cfg_continuous = 1'b0;
    bus.adc_valid = 1'b0; bus.adc_data = '0; bus.tx_ack = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    vecs[0] = '{"basic", 7'd4, 1'b0, 12'h000, 4,
                '{12'h111, 12'h222, 12'h333, 12'h444, 12'h0, 12'h0, 12'h0, 12'h0},
                4, '{12'h111, 12'h222, 12'h333, 12'h444, 12'h0, 12'h0, 12'h0, 12'h0}};
    vecs[1] = '{"trigger", 7'd3, 1'b1, 12'h800, 5,
                '{12'h100, 12'h7FF, 12'h800, 12'h900, 12'h050, 12'h0, 12'h0, 12'h0},
                3, '{12'h800, 12'h900, 12'h050, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    vecs[2] = '{"trig_count1", 7'd1, 1'b1, 12'h400, 3,
                '{12'h3FF, 12'h400, 12'h555, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                1, '{12'h400, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    vecs[3] = '{"count1", 7'd1, 1'b0, 12'h000, 1,
                '{12'hABC, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                1, '{12'hABC, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    vecs[4] = '{"thr_max", 7'd2, 1'b1, 12'hFFF, 3,
                '{12'h7FF, 12'hFFF, 12'h001, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                2, '{12'hFFF, 12'h001, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};
    vecs[5] = '{"thr_zero", 7'd2, 1'b1, 12'h000, 2,
                '{12'h000, 12'h123, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0},
                2, '{12'h000, 12'h123, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0}};

    for (int i = 0; i < NV; i++) begin
      feed_q.delete(); exp_q.delete();
      for (int k = 0; k < vecs[i].n_feed; k++) feed_q.push_back(vecs[i].feed[k]);
      for (int k = 0; k < vecs[i].n_exp; k++)  exp_q.push_back(vecs[i].exp_w[k]);
      run(vecs[i].name, vecs[i].count, vecs[i].trig, vecs[i].thr, 1'b0, 1, 0, 1'b0, 0);
      chk({vecs[i].name, " captured"},    32'(captured),    32'(vecs[i].n_exp));
      chk({vecs[i].name, " transmitted"}, 32'(transmitted), 32'(vecs[i].n_exp));
      chk({vecs[i].name, " idle"},        32'(busy),        32'd0);
    end

    // Strobes in IDLE must not touch the held counters.
    bus.adc_valid = 1'b1; bus.adc_data = 12'hFFF; bus.tx_ack = 1'b1;
    step();
    bus.adc_valid = 1'b0; bus.tx_ack = 1'b0;
    step();
    chk("idle_strobe captured",    32'(captured),    32'd2);
    chk("idle_strobe transmitted", 32'(transmitted), 32'd2);
    chk("idle_strobe busy",        32'(busy),        32'd0);

    // Continuous: three runs of two samples.
    feed_q.delete(); exp_q.delete();
    for (int k = 1; k <= 6; k++) begin
      feed_q.push_back(12'(k * 16));
      exp_q.push_back(12'(k * 16));
    end
    run("continuous", 7'd2, 1'b0, 12'h000, 1'b1, 3, 0, 1'b0, 0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("cont_reset busy", 32'(busy), 32'd0);
    step();

    // Count clamp: 0 means a full buffer.
    feed_q.delete(); exp_q.delete();
    for (int k = 0; k < 150; k++) feed_q.push_back(12'(k));
    for (int k = 0; k < 100; k++) exp_q.push_back(12'(k));
    run("clamp", 7'd0, 1'b0, 12'h000, 1'b0, 1, 0, 1'b0, 100);
    chk("clamp captured",    32'(captured),    32'd100);
    chk("clamp transmitted", 32'(transmitted), 32'd100);

    // Handshake abuse during DRAIN gaps.
    feed_q.delete(); exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      feed_q.push_back(12'(12'hA00 + k));
      exp_q.push_back(12'(12'hA00 + k));
    end
    run("abuse", 7'd4, 1'b0, 12'h000, 1'b0, 1, 0, 1'b1, 0);
    chk("abuse captured",    32'(captured),    32'd4);
    chk("abuse transmitted", 32'(transmitted), 32'd4);
    step(); step(); step();
    chk("abuse no_restart", 32'(busy), 32'd0);

    // Reset after 2 of 4 acks.
    feed_q.delete(); exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      feed_q.push_back(12'(12'hB00 + k));
      exp_q.push_back(12'(12'hB00 + k));
    end
    run("rst_drain", 7'd4, 1'b0, 12'h000, 1'b0, 1, 2, 1'b0, 0);
    chk("rst_drain transmitted_before", 32'(transmitted), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("rst_drain after");
    done_seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (done) done_seen++;
      step();
    end
    chk("rst_drain no_done", 32'(done_seen), 32'd0);
    chk("rst_drain idle",    32'(busy),      32'd0);

    feed_q.delete(); exp_q.delete();
    feed_q.push_back(12'hC01); feed_q.push_back(12'hC02);
    exp_q.push_back(12'hC01);  exp_q.push_back(12'hC02);
    run("restart", 7'd2, 1'b0, 12'h000, 1'b0, 1, 0, 1'b0, 0);
    chk("restart captured",    32'(captured),    32'd2);
    chk("restart transmitted", 32'(transmitted), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
